pwm_duty_decoder: RTL and testbench

PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_duty_decoder_if.sv | 31 +++
 rtl/phase_duty_counter.sv | 75 +++++++
 rtl/pwm_duty_decoder.sv | 145 ++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared state/operation enums and default sizing for the PWM duty decoder.
package pwm_pkg;

    localparam int          DEFAULT_WIDTH      = 16;
    localparam int unsigned DEFAULT_MAX_PERIOD = 32'h0000_FFFF;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        MEASURE   = 2'd1,
        TIMEOUT   = 2'd2
    } state_e;

    // Counter operation broadcast from the FSM to the period and per-phase counters.
    typedef enum logic [1:0] {
        CNT_CLEAR   = 2'd0,
        CNT_RESTART = 2'd1,
        CNT_INCR    = 2'd2
    } cnt_op_e;

endpackage

// File: rtl/pwm_duty_decoder_if.sv
// Signal bundle around pwm_duty_decoder: gate/sync stimulus in, duty/period/status out.
// The master side drives the gates, the slave side is the decoder.
interface pwm_duty_decoder_if #(
    parameter int WIDTH = pwm_pkg::DEFAULT_WIDTH
);
    logic             Va;
    logic             Van;
    logic             Vb;
    logic             Vbn;
    logic             Vc;
    logic             Vcn;
    logic             sync;
    logic             fault_clr;
    logic [WIDTH-1:0] duty_a;
    logic [WIDTH-1:0] duty_b;
    logic [WIDTH-1:0] duty_c;
    logic [WIDTH-1:0] period;
    logic             valid;
    logic             timeout;
    logic [2:0]       fault;

    modport master (
        output Va, Van, Vb, Vbn, Vc, Vcn, sync, fault_clr,
        input  duty_a, duty_b, duty_c, period, valid, timeout, fault
    );

    modport slave (
        input  Va, Van, Vb, Vbn, Vc, Vcn, sync, fault_clr,
        output duty_a, duty_b, duty_c, period, valid, timeout, fault
    );
endinterface

// File: rtl/phase_duty_counter.sv
// One phase: saturating high-time counter with capture register and sticky shoot-through flag.
// Shoot-through detection is compiled in only when PWM_FAULT_DETECT_EN is defined.
module phase_duty_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  cnt_op_e          i_cnt_op,
    input  logic             i_capture,
    input  logic             i_v,
    input  logic             i_vn,
    input  logic             i_fault_clr,
    output logic [WIDTH-1:0] o_duty,
    output logic             o_fault
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] r_duty;

    always_comb begin
        w_cnt_next = r_cnt;
        case (i_cnt_op)
            CNT_RESTART: w_cnt_next = {{(WIDTH-1){1'b0}}, i_v};
            CNT_INCR: begin
                if (i_v && (r_cnt != CNT_MAX)) begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            default: w_cnt_next = '0;
        endcase
    end

    // Capture takes the count before the restart sample is folded in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_duty <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (i_capture) begin
                r_duty <= r_cnt;
            end
        end
    end

    assign o_duty = r_duty;

`ifdef PWM_FAULT_DETECT_EN
    logic r_fault;

    // A new shoot-through has priority over a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (i_v && i_vn) begin
            r_fault <= 1'b1;
        end else if (i_fault_clr) begin
            r_fault <= 1'b0;
        end
    end

    assign o_fault = r_fault;
`else
    logic w_unused_fault_inputs;
    assign w_unused_fault_inputs = i_vn ^ i_fault_clr;
    assign o_fault = 1'b0;
`endif

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures per-phase high time and carrier period between sync pulses of a 3-phase PWM.
// Optional shoot-through detection: define PWM_FAULT_DETECT_EN.
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int          WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned MAX_PERIOD = DEFAULT_MAX_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Va,
    input  logic             Van,
    input  logic             Vb,
    input  logic             Vbn,
    input  logic             Vc,
    input  logic             Vcn,
    input  logic             sync,
    input  logic             fault_clr,
    output logic [WIDTH-1:0] duty_a,
    output logic [WIDTH-1:0] duty_b,
    output logic [WIDTH-1:0] duty_c,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             timeout,
    output logic [2:0]       fault
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       r_v;
    logic [2:0]       r_vn;
    logic             r_sync;

    state_e           r_state;
    state_e           w_state_next;
    cnt_op_e          w_cnt_op;
    logic             w_capture;
    logic             w_at_max;

    logic [WIDTH-1:0] r_period_cnt;
    logic [WIDTH-1:0] r_period;
    logic             r_valid;

    logic [WIDTH-1:0] w_duty [3];
    logic [2:0]       w_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v    <= '0;
            r_vn   <= '0;
            r_sync <= 1'b0;
        end else begin
            r_v    <= {Vc, Vb, Va};
            r_vn   <= {Vcn, Vbn, Van};
            r_sync <= sync;
        end
    end

    // The saturated count is widened so a MAX_PERIOD beyond 2^WIDTH-1 never times out.
    assign w_at_max = (32'(r_period_cnt) >= MAX_PERIOD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_op     = CNT_CLEAR;
        w_capture    = 1'b0;
        case (r_state)
            WAIT_SYNC, TIMEOUT: begin
                if (r_sync) begin
                    w_state_next = MEASURE;
                    w_cnt_op     = CNT_RESTART;
                end
            end
            MEASURE: begin
                if (r_sync) begin
                    w_cnt_op  = CNT_RESTART;
                    w_capture = 1'b1;
                end else if (w_at_max) begin
                    w_state_next = TIMEOUT;
                end else begin
                    w_cnt_op = CNT_INCR;
                end
            end
            default: w_state_next = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_cnt <= '0;
            r_period     <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_period <= r_period_cnt;
            end
            case (w_cnt_op)
                CNT_RESTART: r_period_cnt <= CNT_ONE;
                CNT_INCR: begin
                    if (r_period_cnt != CNT_MAX) begin
                        r_period_cnt <= r_period_cnt + CNT_ONE;
                    end
                end
                default: r_period_cnt <= '0;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_phase
            phase_duty_counter #(
                .WIDTH(WIDTH)
            ) u_phase (
                .clk        (clk),
                .reset      (reset),
                .i_cnt_op   (w_cnt_op),
                .i_capture  (w_capture),
                .i_v        (r_v[gi]),
                .i_vn       (r_vn[gi]),
                .i_fault_clr(fault_clr),
                .o_duty     (w_duty[gi]),
                .o_fault    (w_fault[gi])
            );
        end
    endgenerate

    assign duty_a  = w_duty[0];
    assign duty_b  = w_duty[1];
    assign duty_c  = w_duty[2];
    assign period  = r_period;
    assign valid   = r_valid;
    assign timeout = (r_state == TIMEOUT);
    assign fault   = w_fault;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench: three decoder builds (default, MAX_PERIOD=50, WIDTH=8) share one stimulus stream;
// a period-level reference model per build predicts every cycle's outputs and each valid record.
module tb_pwm_duty_decoder;
    import pwm_pkg::*;

    typedef struct packed {
        logic        valid;
        logic        timeout;
        logic [2:0]  fault;
        logic [15:0] duty_a;
        logic [15:0] duty_b;
        logic [15:0] duty_c;
        logic [15:0] period;
    } obs_t;

    typedef struct packed {
        logic [15:0] duty_a;
        logic [15:0] duty_b;
        logic [15:0] duty_c;
        logic [15:0] period;
    } txn_t;

`ifdef PWM_FAULT_DETECT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sync;
    logic       fault_clr;
    logic [2:0] v;
    logic [2:0] vn;

    int n_cmp = 0;
    int n_err = 0;
    bit stim_done = 1'b0;

    always #5 clk = ~clk;

    function automatic int sat(input int x, input int m);
        return (x > m) ? m : x;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int W    = (gi == 2) ? 8 : 16;
            localparam int MAXP = (gi == 1) ? 50 : 65535;
            localparam int SAT  = (1 << W) - 1;

            pwm_duty_decoder_if #(.WIDTH(W)) bus ();

            assign bus.Va        = v[0];
            assign bus.Vb        = v[1];
            assign bus.Vc        = v[2];
            assign bus.Van       = vn[0];
            assign bus.Vbn       = vn[1];
            assign bus.Vcn       = vn[2];
            assign bus.sync      = sync;
            assign bus.fault_clr = fault_clr;

            pwm_duty_decoder #(
                .WIDTH     (W),
                .MAX_PERIOD(MAXP)
            ) dut (
                .clk      (clk),
                .reset    (reset),
                .Va       (bus.Va),
                .Van      (bus.Van),
                .Vb       (bus.Vb),
                .Vbn      (bus.Vbn),
                .Vc       (bus.Vc),
                .Vcn      (bus.Vcn),
                .sync     (bus.sync),
                .fault_clr(bus.fault_clr),
                .duty_a   (bus.duty_a),
                .duty_b   (bus.duty_b),
                .duty_c   (bus.duty_c),
                .period   (bus.period),
                .valid    (bus.valid),
                .timeout  (bus.timeout),
                .fault    (bus.fault)
            );

            obs_t exp_q[$];
            txn_t txn_q[$];

            // Reference: a period is the samples from one sync (inclusive) to the next (exclusive);
            // gate samples count one clock after they are taken, fault_clr acts immediately.
            initial begin : model
                bit         measuring;
                bit         timed_out;
                int         len;
                int         hi[3];
                logic [2:0] flt;
                logic       p_sync;
                logic [2:0] p_v;
                logic [2:0] p_vn;
                txn_t       last;
                obs_t       e;
                measuring = 1'b0;
                timed_out = 1'b0;
                len       = 0;
                hi        = '{0, 0, 0};
                flt       = '0;
                p_sync    = 1'b0;
                p_v       = '0;
                p_vn      = '0;
                last      = '0;
                forever begin
                    @(posedge clk);
                    e = '0;
                    if (reset) begin
                        measuring = 1'b0;
                        timed_out = 1'b0;
                        len       = 0;
                        hi        = '{0, 0, 0};
                        flt       = '0;
                        last      = '0;
                    end else begin
                        if (p_sync) begin
                            if (measuring) begin
                                last.duty_a = 16'(sat(hi[0], SAT));
                                last.duty_b = 16'(sat(hi[1], SAT));
                                last.duty_c = 16'(sat(hi[2], SAT));
                                last.period = 16'(sat(len, SAT));
                                txn_q.push_back(last);
                                e.valid = 1'b1;
                            end
                            measuring = 1'b1;
                            timed_out = 1'b0;
                            len       = 1;
                            for (int k = 0; k < 3; k++) hi[k] = int'(p_v[k]);
                        end else if (measuring) begin
                            if (sat(len, SAT) >= MAXP) begin
                                measuring = 1'b0;
                                timed_out = 1'b1;
                                len       = 0;
                                hi        = '{0, 0, 0};
                            end else begin
                                len++;
                                for (int k = 0; k < 3; k++) hi[k] += int'(p_v[k]);
                            end
                        end
                        for (int k = 0; k < 3; k++) begin
                            if (FAULT_EN && p_v[k] && p_vn[k]) flt[k] = 1'b1;
                            else if (FAULT_EN && fault_clr) flt[k] = 1'b0;
                        end
                    end
                    e.timeout = timed_out;
                    e.fault   = flt;
                    e.duty_a  = last.duty_a;
                    e.duty_b  = last.duty_b;
                    e.duty_c  = last.duty_c;
                    e.period  = last.period;
                    exp_q.push_back(e);
                    p_sync = reset ? 1'b0 : sync;
                    p_v    = reset ? 3'b000 : v;
                    p_vn   = reset ? 3'b000 : vn;
                end
            end

            initial begin : monitor
                obs_t e;
                obs_t got;
                txn_t t;
                txn_t gt;
                forever begin
                    @(posedge clk);
                    #1;
                    if (exp_q.size() != 0) begin
                        e           = exp_q.pop_front();
                        got.valid   = bus.valid;
                        got.timeout = bus.timeout;
                        got.fault   = bus.fault;
                        got.duty_a  = 16'(bus.duty_a);
                        got.duty_b  = 16'(bus.duty_b);
                        got.duty_c  = 16'(bus.duty_c);
                        got.period  = 16'(bus.period);
                        n_cmp++;
                        if (got !== e) begin
                            n_err++;
                            $display("FAIL dut%0d status @%0t: got v=%b to=%b f=%b d=%0d/%0d/%0d p=%0d, need v=%b to=%b f=%b d=%0d/%0d/%0d p=%0d",
                                     gi, $time, got.valid, got.timeout, got.fault, got.duty_a, got.duty_b,
                                     got.duty_c, got.period, e.valid, e.timeout, e.fault, e.duty_a,
                                     e.duty_b, e.duty_c, e.period);
                        end
                        if (bus.valid === 1'b1) begin
                            n_cmp++;
                            if (txn_q.size() == 0) begin
                                n_err++;
                                $display("FAIL dut%0d txn @%0t: unexpected valid d=%0d/%0d/%0d p=%0d",
                                         gi, $time, got.duty_a, got.duty_b, got.duty_c, got.period);
                            end else begin
                                t         = txn_q.pop_front();
                                gt.duty_a = got.duty_a;
                                gt.duty_b = got.duty_b;
                                gt.duty_c = got.duty_c;
                                gt.period = got.period;
                                if (gt !== t) begin
                                    n_err++;
                                    $display("FAIL dut%0d txn @%0t: got d=%0d/%0d/%0d p=%0d, need d=%0d/%0d/%0d p=%0d",
                                             gi, $time, gt.duty_a, gt.duty_b, gt.duty_c, gt.period,
                                             t.duty_a, t.duty_b, t.duty_c, t.period);
                                end else begin
                                    $display("dut%0d txn @%0t: duty=%0d/%0d/%0d period=%0d ok",
                                             gi, $time, gt.duty_a, gt.duty_b, gt.duty_c, gt.period);
                                end
                            end
                        end
                    end
                end
            end

            initial begin : drain
                wait (stim_done);
                n_cmp++;
                if (txn_q.size() != 0) begin
                    n_err++;
                    $display("FAIL dut%0d drain: got %0d missing valid(s), need 0", gi, txn_q.size());
                end
            end
        end
    endgenerate

    task automatic drive(input bit s, input bit [2:0] vv, input bit [2:0] vvn, input bit clr);
        @(negedge clk);
        reset     = 1'b0;
        sync      = s;
        v         = vv;
        vn        = vvn;
        fault_clr = clr;
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            reset     = 1'b1;
            sync      = 1'b0;
            v         = '0;
            vn        = '0;
            fault_clr = 1'b0;
        end
    endtask

    // Complementary gates: Va high for the first hi_a cycles, Vb/Vc constant.
    task automatic run_period(input int len, input int hi_a, input bit vb, input bit vc);
        bit [2:0] g;
        for (int i = 0; i < len; i++) begin
            g = {vc, vb, (i < hi_a)};
            drive(i == 0, g, ~g, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'b000, 3'b111, 1'b0);
    endtask

    initial begin
        bit [2:0] rv;
        bit [2:0] rvn;
        int       plen;
        reset     = 1'b1;
        sync      = 1'b0;
        fault_clr = 1'b0;
        v         = '0;
        vn        = '0;
        do_reset(3);

        for (int p = 0; p < 3; p++) run_period(100, 30, 1'b1, 1'b0);
        run_period(50, 10, 1'b0, 1'b1);
        run_period(51, 51, 1'b1, 1'b1);
        run_period(50, 0, 1'b0, 1'b0);
        run_period(50, 50, 1'b1, 1'b0);
        run_period(1, 1, 1'b0, 1'b0);
        run_period(1, 0, 1'b1, 1'b0);

        drive(1'b0, 3'b001, 3'b001, 1'b0);
        idle(5);
        drive(1'b0, 3'b000, 3'b111, 1'b1);
        idle(3);
        drive(1'b0, 3'b010, 3'b010, 1'b1);
        idle(4);
        drive(1'b0, 3'b100, 3'b100, 1'b0);
        drive(1'b0, 3'b000, 3'b111, 1'b1);
        idle(3);
        drive(1'b0, 3'b000, 3'b000, 1'b1);
        idle(2);

        run_period(100, 30, 1'b1, 1'b0);
        run_period(40, 30, 1'b1, 1'b0);
        do_reset(2);
        for (int p = 0; p < 3; p++) run_period(100, 30, 1'b1, 1'b0);

        run_period(300, 300, 1'b1, 1'b0);
        run_period(300, 300, 1'b1, 1'b0);
        run_period(60, 20, 1'b0, 1'b0);
        run_period(100, 70, 1'b0, 1'b1);

        for (int p = 0; p < 25; p++) begin
            plen = int'($urandom_range(1, 120));
            for (int i = 0; i < plen; i++) begin
                for (int k = 0; k < 3; k++) begin
                    rv[k] = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 63))
                        0:       rvn[k] = 1'b1;
                        1:       rvn[k] = 1'b0;
                        default: rvn[k] = ~rv[k];
                    endcase
                end
                drive(i == 0, rv, rvn, ($urandom_range(0, 39) == 0));
            end
        end
        run_period(1, 0, 1'b0, 1'b0);
        idle(5);

        stim_done = 1'b1;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
